// File: rtl/not_gate_resp_checker_pkg.sv
// Shared types and limits for the inverter response checker.
// Holds the run-state encoding and the supported latency bound.
package not_gate_resp_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int LATENCY_MAX = 7;

  // Out-of-range latencies fold onto the nearest legal depth.
  function automatic int clamp_lat(
    input int lat
  );
    if (lat > LATENCY_MAX) begin
      return LATENCY_MAX;
    end
    if (lat < 0) begin
      return 0;
    end
    return lat;
  endfunction

endpackage

// File: rtl/not_gate_resp_checker_if.sv
// Stimulus/response/result bundle between harness and checker.
// The master drives vectors; the slave (checker) reports results.
interface not_gate_resp_checker_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);

  logic             start;
  logic             stim_valid;
  logic [WIDTH-1:0] stim;
  logic [WIDTH-1:0] resp;

  logic             busy;
  logic             done;
  logic             pass;
  logic             err_sticky;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [CNT_W-1:0] first_fail_idx;
  logic [WIDTH-1:0] first_fail_stim;
  logic [WIDTH-1:0] first_fail_resp;

  modport master (
    output start,
    output stim_valid,
    output stim,
    output resp,
    input  busy,
    input  done,
    input  pass,
    input  err_sticky,
    input  match_cnt,
    input  mismatch_cnt,
    input  first_fail_idx,
    input  first_fail_stim,
    input  first_fail_resp
  );

  modport slave (
    input  start,
    input  stim_valid,
    input  stim,
    input  resp,
    output busy,
    output done,
    output pass,
    output err_sticky,
    output match_cnt,
    output mismatch_cnt,
    output first_fail_idx,
    output first_fail_stim,
    output first_fail_resp
  );

endinterface

// File: rtl/not_gate_resp_checker_exp_delay_line.sv
// Valid/data shift register aligning expected values to DUT latency.
// DEPTH of zero degenerates to a combinational pass-through.
module not_gate_resp_checker_exp_delay_line #(
  parameter int DEPTH = 0,
  parameter int DW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          vld_i,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  output logic [DW-1:0] data_o
);

  if (DEPTH == 0) begin : g_thru

    logic unused_ctl;
    assign unused_ctl = ^{clk, rst_n, clr_i};

    assign vld_o  = vld_i;
    assign data_o = data_i;

  end else begin : g_pipe

    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else if (clr_i) begin
        vld_q <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i] <= '0;
        end
      end else begin
        vld_q[0]  <= vld_i;
        data_q[0] <= data_i;
        for (int i = 1; i < DEPTH; i++) begin
          vld_q[i]  <= vld_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end
    end

    assign vld_o  = vld_q[DEPTH-1];
    assign data_o = data_q[DEPTH-1];

  end

endmodule

// File: rtl/not_gate_resp_checker.sv
// Self-checking monitor for an inverter: compares resp to ~stim
// after the DUT latency and keeps pass/fail stats per run.
module not_gate_resp_checker
  import not_gate_resp_checker_pkg::*;
#(
  parameter int WIDTH       = 1,
  parameter int LATENCY     = 0,
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  not_gate_resp_checker_if.slave bus
);

  localparam int DEPTH = clamp_lat(LATENCY);
  localparam int DW    = 2 * WIDTH + CNT_W;

  localparam logic [CNT_W-1:0] NV   = CNT_W'(NUM_VECTORS);
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e           state_q;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] chk_cnt_q;
  logic [CNT_W-1:0] match_q;
  logic [CNT_W-1:0] mism_q;
  logic [CNT_W-1:0] ff_idx_q;
  logic [WIDTH-1:0] ff_stim_q;
  logic [WIDTH-1:0] ff_resp_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             err_q;

  logic             launch;
  logic             accept;
  logic             tap_vld;
  logic             cmp_en;
  logic             hit;
  logic [DW-1:0]    push_data;
  logic [DW-1:0]    tap_data;
  logic [WIDTH-1:0] tap_exp;
  logic [WIDTH-1:0] tap_stim;
  logic [CNT_W-1:0] tap_idx;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CMAX) ? v : v + 1'b1;
  endfunction

  // start only launches from IDLE/DONE; a pulse during RUN is ignored.
  assign launch = bus.start && (state_q != RUN);

  assign accept = (state_q == RUN)
               && bus.stim_valid
               && (acc_cnt_q < NV);

  assign push_data = {~bus.stim, bus.stim, acc_cnt_q};

  not_gate_resp_checker_exp_delay_line #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (launch),
    .vld_i  (accept),
    .data_i (push_data),
    .vld_o  (tap_vld),
    .data_o (tap_data)
  );

  assign {tap_exp, tap_stim, tap_idx} = tap_data;

  assign cmp_en = tap_vld && (state_q == RUN);
  assign hit    = (bus.resp == tap_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      chk_cnt_q <= '0;
      match_q   <= '0;
      mism_q    <= '0;
      ff_idx_q  <= '0;
      ff_stim_q <= '0;
      ff_resp_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (launch) begin
            state_q   <= RUN;
            acc_cnt_q <= '0;
            chk_cnt_q <= '0;
            match_q   <= '0;
            mism_q    <= '0;
            ff_idx_q  <= '0;
            ff_stim_q <= '0;
            ff_resp_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt_q <= acc_cnt_q + 1'b1;
          end
          if (cmp_en) begin
            chk_cnt_q <= chk_cnt_q + 1'b1;
            if (hit) begin
              match_q <= sat_inc(match_q);
            end else begin
              mism_q <= sat_inc(mism_q);
              if (!err_q) begin
                err_q     <= 1'b1;
                ff_idx_q  <= tap_idx;
                ff_stim_q <= tap_stim;
                ff_resp_q <= bus.resp;
              end
            end
          end
          // All comparisons registered: results are final this cycle.
          if (chk_cnt_q == NV) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (mism_q == '0);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_sticky      = err_q;
  assign bus.match_cnt       = match_q;
  assign bus.mismatch_cnt    = mism_q;
  assign bus.first_fail_idx  = ff_idx_q;
  assign bus.first_fail_stim = ff_stim_q;
  assign bus.first_fail_resp = ff_resp_q;

endmodule

// File: tb/tb_not_gate_resp_checker.sv
// Directed-vector bench for the inverter response checker.
// Drives a zero-latency and a two-cycle-latency instance.
module tb_not_gate_resp_checker;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  not_gate_resp_checker_if #(.WIDTH(1), .CNT_W(8)) if0 ();
  not_gate_resp_checker_if #(.WIDTH(1), .CNT_W(8)) if2 ();

  not_gate_resp_checker #(
    .WIDTH(1), .LATENCY(0), .NUM_VECTORS(4), .CNT_W(8)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  not_gate_resp_checker #(
    .WIDTH(1), .LATENCY(2), .NUM_VECTORS(4), .CNT_W(8)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  // Two-cycle inverter model feeding the latency-2 instance.
  logic [1:0] pipe2;
  always @(posedge clk) pipe2 <= {pipe2[0], ~if2.stim};
  assign if2.resp = pipe2[1];

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_vec = 0;
  int n_err = 0;
  int t0;
  int guard;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go0();
    if0.start = 1'b1;
    cyc();
    if0.start = 1'b0;
  endtask

  task automatic vec0(input logic s, input logic r);
    if0.stim_valid = 1'b1;
    if0.stim       = s;
    if0.resp       = r;
    cyc();
    if0.stim_valid = 1'b0;
  endtask

  task automatic wait0(input string tag);
    int g;
    g = 0;
    while (!if0.done && g < 50) begin
      cyc();
      g++;
    end
    chk(tag, if0.done, 1);
  endtask

  task automatic res0(
    input string tag,
    input int    m,
    input int    mm,
    input logic  p,
    input logic  e
  );
    chk({tag, "_match"}, if0.match_cnt, m);
    chk({tag, "_mism"},  if0.mismatch_cnt, mm);
    chk({tag, "_pass"},  if0.pass, p);
    chk({tag, "_err"},   if0.err_sticky, e);
    chk({tag, "_busy"},  if0.busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    if0.start      = 1'b0;
    if0.stim_valid = 1'b0;
    if0.stim       = 1'b0;
    if0.resp       = 1'b0;
    if2.start      = 1'b0;
    if2.stim_valid = 1'b0;
    if2.stim       = 1'b0;
    repeat (2) cyc();

    chk("rst_busy",  if0.busy, 0);
    chk("rst_done",  if0.done, 0);
    chk("rst_match", if0.match_cnt, 0);
    chk("rst2_done", if2.done, 0);

    rst_n = 1'b1;
    cyc();

    // Vectors while IDLE must be dropped.
    vec0(1'b0, 1'b0);
    vec0(1'b1, 1'b1);
    chk("idle_match", if0.match_cnt, 0);
    chk("idle_mism",  if0.mismatch_cnt, 0);
    chk("idle_busy",  if0.busy, 0);

    // All good, latency 0.
    go0();
    t0 = cyc_n;
    chk("t1_busy_run", if0.busy, 1);
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    wait0("t1_done");
    chk("t1_lat", cyc_n - t0, 5);
    res0("t1", 4, 0, 1'b1, 1'b0);

    // resp stuck 0 on vectors 2 and 3: only vector 2 fails.
    go0();
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    vec0(1'b0, 1'b0);
    vec0(1'b1, 1'b0);
    wait0("t2_done");
    res0("t2", 3, 1, 1'b0, 1'b1);
    chk("t2_ff_idx",  if0.first_fail_idx, 2);
    chk("t2_ff_stim", if0.first_fail_stim, 0);
    chk("t2_ff_resp", if0.first_fail_resp, 0);

    // Restart after failure clears; start during RUN ignored.
    go0();
    chk("t5_err_clr",  if0.err_sticky, 0);
    chk("t5_mism_clr", if0.mismatch_cnt, 0);
    chk("t5_done_clr", if0.done, 0);
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    if0.start = 1'b1;
    vec0(1'b0, 1'b1);
    if0.start = 1'b0;
    vec0(1'b1, 1'b0);
    wait0("t5_done");
    res0("t5", 4, 0, 1'b1, 1'b0);

    // Six vectors: last two (bad) must be dropped.
    go0();
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    vec0(1'b0, 1'b0);
    vec0(1'b1, 1'b1);
    wait0("t6_done");
    res0("t6", 4, 0, 1'b1, 1'b0);

    // Latency 2 with one-cycle gaps.
    if2.start = 1'b1;
    cyc();
    if2.start = 1'b0;
    t0 = cyc_n;
    for (int i = 0; i < 4; i++) begin
      if2.stim_valid = 1'b1;
      if2.stim       = i[0];
      cyc();
      if2.stim_valid = 1'b0;
      if2.stim       = ~i[0];
      cyc();
    end
    guard = 0;
    while (!if2.done && guard < 50) begin
      cyc();
      guard++;
    end
    chk("t3_done",  if2.done, 1);
    chk("t3_lat",   cyc_n - t0, 10);
    chk("t3_pass",  if2.pass, 1);
    chk("t3_match", if2.match_cnt, 4);
    chk("t3_mism",  if2.mismatch_cnt, 0);

    // Asynchronous reset mid-run.
    go0();
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b1);
    chk("t4_pre_match", if0.match_cnt, 1);
    chk("t4_pre_err",   if0.err_sticky, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_busy",  if0.busy, 0);
    chk("t4_match", if0.match_cnt, 0);
    chk("t4_mism",  if0.mismatch_cnt, 0);
    chk("t4_err",   if0.err_sticky, 0);
    chk("t4_ffidx", if0.first_fail_idx, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("t4_idle", if0.busy, 0);
    go0();
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    vec0(1'b0, 1'b1);
    vec0(1'b1, 1'b0);
    wait0("t4_done");
    res0("t4r", 4, 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
